i_wr_ctrl: RTL and testbench

I_WR_CTRL -- requirements
Module: i_wr_ctrl

---
 rtl/i_wr_pkg.sv | 15 +
 rtl/i_wr_addr_gen.sv | 70 +++++++
 rtl/i_wr_ctrl.sv | 114 +++++++++++
 tb/tb_i_wr_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i_wr_pkg.sv
// Shared types and constants for the image-read controller.
package i_wr_pkg;

  // Width of the column/row counters and of the frame dimension inputs.
  localparam int unsigned DIM_W = 13;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_PUSH,
    ST_DONE
  } state_t;

endpackage

// File: rtl/i_wr_addr_gen.sv
// Column/row/address tracker for a raster-order frame read.
module i_wr_addr_gen
  import i_wr_pkg::*;
#(
  parameter int unsigned ADDR_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              advance,
  input  logic [DIM_W-1:0]  width,
  input  logic [DIM_W-1:0]  height,
  input  logic [ADDR_W-1:0] base,
  output logic [ADDR_W-1:0] addr,
  output logic              eol,
  output logic              last
);

  logic [DIM_W-1:0]  width_q,  width_d;
  logic [DIM_W-1:0]  height_q, height_d;
  logic [DIM_W-1:0]  col_q,    col_d;
  logic [DIM_W-1:0]  row_q,    row_d;
  logic [ADDR_W-1:0] addr_q,   addr_d;

  assign eol  = (col_q == width_q - DIM_W'(1));
  assign last = eol && (row_q == height_q - DIM_W'(1));
  assign addr = addr_q;

  // Latch frame geometry on clear; step raster position on advance.
  always_comb begin
    width_d  = width_q;
    height_d = height_q;
    col_d    = col_q;
    row_d    = row_q;
    addr_d   = addr_q;
    if (clear) begin
      width_d  = width;
      height_d = height;
      col_d    = '0;
      row_d    = '0;
      addr_d   = base;
    end else if (advance) begin
      if (eol) begin
        col_d = '0;
        row_d = row_q + DIM_W'(1);
      end else begin
        col_d = col_q + DIM_W'(1);
      end
      addr_d = addr_q + ADDR_W'(1);
    end
  end

  // Position and geometry registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      width_q  <= '0;
      height_q <= '0;
      col_q    <= '0;
      row_q    <= '0;
      addr_q   <= '0;
    end else begin
      width_q  <= width_d;
      height_q <= height_d;
      col_q    <= col_d;
      row_q    <= row_d;
      addr_q   <= addr_d;
    end
  end

endmodule

// File: rtl/i_wr_ctrl.sv
// Frame reader: fetches pixels from SRAM one at a time and pushes them
// downstream with row/frame markers.
module i_wr_ctrl
  import i_wr_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIM_W-1:0]  img_width,
  input  logic [DIM_W-1:0]  img_height,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              sram_rd_req,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic              sram_rd_done,
  input  logic [DATA_W-1:0] sram_rd_data,
  output logic              pix_valid,
  output logic [DATA_W-1:0] pix_data,
  input  logic              pix_ready,
  output logic              pix_eol,
  output logic              pix_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] pix_data_q, pix_data_d;
  logic              err_q, err_d;
  logic              clear, advance;
  logic [ADDR_W-1:0] addr;
  logic              eol, last;

  i_wr_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .advance (advance),
    .width   (img_width),
    .height  (img_height),
    .base    (base_addr),
    .addr    (addr),
    .eol     (eol),
    .last    (last)
  );

  // Next-state, counter control and rejected-start detection.
  always_comb begin
    state_d    = state_q;
    clear      = 1'b0;
    advance    = 1'b0;
    err_d      = 1'b0;
    pix_data_d = pix_data_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if ((img_width != '0) && (img_height != '0)) begin
            clear   = 1'b1;
            state_d = ST_REQ;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_REQ:  state_d = ST_WAIT;
      ST_WAIT: begin
        if (sram_rd_done) begin
          pix_data_d = sram_rd_data;
          state_d    = ST_PUSH;
        end
      end
      ST_PUSH: begin
        if (pix_ready) begin
          if (last) begin
            state_d = ST_DONE;
          end else begin
            advance = 1'b1;
            state_d = ST_REQ;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, captured pixel and error pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pix_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pix_data_q <= pix_data_d;
      err_q      <= err_d;
    end
  end

  assign sram_rd_req = (state_q == ST_REQ);
  assign sram_addr   = sram_rd_req ? addr : '0;
  assign pix_valid   = (state_q == ST_PUSH);
  assign pix_data    = pix_data_q;
  assign pix_eol     = pix_valid && eol;
  assign pix_last    = pix_valid && last;
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign err         = err_q;

endmodule

// File: tb/tb_i_wr_ctrl.sv
// Bench for the frame reader: the SRAM and the downstream sink are modelled
// here; expected addresses and markers come from the raster index of each pixel.
module tb_i_wr_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [12:0] img_width, img_height;
  logic [23:0] base_addr;
  logic        sram_rd_req;
  logic [23:0] sram_addr;
  logic        sram_rd_done;
  logic [7:0]  sram_rd_data;
  logic        pix_valid;
  logic [7:0]  pix_data;
  logic        pix_ready;
  logic        pix_eol, pix_last, busy, done, err;

  int n_checks = 0;
  int n_errors = 0;

  logic [38:0] all_outs;
  assign all_outs = {sram_rd_req, sram_addr, pix_valid, pix_data, pix_eol,
                     pix_last, busy, done, err};

  i_wr_ctrl #(.DATA_W(8), .ADDR_W(24)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .img_width    (img_width),
    .img_height   (img_height),
    .base_addr    (base_addr),
    .sram_rd_req  (sram_rd_req),
    .sram_addr    (sram_addr),
    .sram_rd_done (sram_rd_done),
    .sram_rd_data (sram_rd_data),
    .pix_valid    (pix_valid),
    .pix_data     (pix_data),
    .pix_ready    (pix_ready),
    .pix_eol      (pix_eol),
    .pix_last     (pix_last),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; img_width = '0; img_height = '0; base_addr = '0;
    sram_rd_done = 1'b0; sram_rd_data = '0; pix_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (all_outs !== '0) begin
      n_errors++; $display("FAIL reset_outputs: got %h want 0", all_outs);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (all_outs !== '0) begin
      n_errors++; $display("FAIL idle_after_reset: got %h want 0", all_outs);
    end
  endtask

  // Runs one frame. rst_pix >= 0 asserts reset while that pixel is in WAIT.
  task automatic run_frame(input int w, input int h, input logic [23:0] base,
                           input bit rnd, input int stall_pix, input int stall_len,
                           input bit poke, input int rst_pix);
    logic [23:0] exp_addr;
    logic [7:0]  d;
    bit          exp_eol, exp_last;
    int          n, budget, dly, stall;
    n = w * h;
    @(negedge clk);
    start = 1'b1; img_width = 13'(w); img_height = 13'(h); base_addr = base;
    @(negedge clk);
    start = 1'b0; img_width = 13'($urandom); img_height = 13'($urandom);
    base_addr = 24'($urandom);
    n_checks++;
    if (sram_rd_req !== 1'b1 || busy !== 1'b1) begin
      n_errors++; $display("FAIL start_latency: req=%b busy=%b want 1 1", sram_rd_req, busy);
    end
    for (int i = 0; i < n; i++) begin
      exp_addr = base + 24'(i);
      exp_eol  = ((i % w) == (w - 1));
      exp_last = (i == n - 1);
      budget = 0;
      while (sram_rd_req !== 1'b1 && budget < 20) begin
        @(negedge clk); budget++;
      end
      n_checks++;
      if (sram_rd_req !== 1'b1 || sram_addr !== exp_addr) begin
        n_errors++;
        $display("FAIL read_addr pix %0d: req=%b addr=%h want req=1 addr=%h",
                 i, sram_rd_req, sram_addr, exp_addr);
        if (budget >= 20) return;
      end
      @(negedge clk);
      n_checks++;
      if (sram_rd_req !== 1'b0) begin
        n_errors++; $display("FAIL req_one_cycle pix %0d: req=%b want 0", i, sram_rd_req);
      end
      if (i == rst_pix) begin
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if (all_outs !== '0) begin
          n_errors++; $display("FAIL async_reset: outs=%h want 0", all_outs);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          n_checks++;
          if (all_outs !== '0) begin
            n_errors++; $display("FAIL post_reset_quiet cyc %0d: outs=%h want 0", k, all_outs);
          end
        end
        return;
      end
      dly = rnd ? int'($urandom_range(0, 2)) : 0;
      repeat (dly) @(negedge clk);
      d = 8'($urandom);
      sram_rd_done = 1'b1; sram_rd_data = d;
      @(negedge clk);
      sram_rd_done = 1'b0; sram_rd_data = 8'($urandom);
      n_checks++;
      if (pix_valid !== 1'b1 || pix_data !== d || pix_eol !== exp_eol || pix_last !== exp_last) begin
        n_errors++;
        $display("FAIL pixel pix %0d: v=%b data=%h eol=%b last=%b want v=1 data=%h eol=%b last=%b",
                 i, pix_valid, pix_data, pix_eol, pix_last, d, exp_eol, exp_last);
      end
      stall = rnd ? int'($urandom_range(0, 3)) : ((i == stall_pix) ? stall_len : 0);
      for (int s = 0; s < stall; s++) begin
        pix_ready = 1'b0;
        sram_rd_done = 1'($urandom_range(0, 1));
        start = poke;
        if (poke) begin
          img_width = 13'($urandom_range(0, 3)); img_height = 13'($urandom_range(0, 3));
        end
        @(negedge clk);
        n_checks++;
        if (pix_valid !== 1'b1 || pix_data !== d || pix_eol !== exp_eol ||
            pix_last !== exp_last || sram_rd_req !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
          n_errors++;
          $display("FAIL stall_hold pix %0d: v=%b data=%h eol=%b last=%b req=%b done=%b err=%b want 1 %h %b %b 0 0 0",
                   i, pix_valid, pix_data, pix_eol, pix_last, sram_rd_req, done, err,
                   d, exp_eol, exp_last);
        end
      end
      sram_rd_done = 1'b0; start = poke; pix_ready = 1'b1;
      @(negedge clk);
      pix_ready = 1'b0; start = 1'b0;
      if (exp_last) begin
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b1 || pix_valid !== 1'b0) begin
          n_errors++;
          $display("FAIL done_pulse: done=%b busy=%b v=%b want 1 1 0", done, busy, pix_valid);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
          n_errors++; $display("FAIL back_to_idle: done=%b busy=%b want 0 0", done, busy);
        end
      end
    end
  endtask

  task automatic test_basic_2x2();
    run_frame(2, 2, 24'h000100, 1'b0, -1, 0, 1'b0, -1);
  endtask

  task automatic test_stall_3x1();
    run_frame(3, 1, 24'h000040, 1'b0, 1, 5, 1'b0, -1);
  endtask

  task automatic test_zero_dim();
    int wv [2] = '{0, 3};
    int hv [2] = '{5, 0};
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      start = 1'b1; img_width = 13'(wv[t]); img_height = 13'(hv[t]); base_addr = 24'h123;
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if (err !== 1'b1 || busy !== 1'b0 || sram_rd_req !== 1'b0) begin
        n_errors++;
        $display("FAIL zero_dim_err case %0d: err=%b busy=%b req=%b want 1 0 0", t, err, busy, sram_rd_req);
      end
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        n_checks++;
        if (err !== 1'b0 || busy !== 1'b0 || sram_rd_req !== 1'b0) begin
          n_errors++;
          $display("FAIL zero_dim_quiet case %0d: err=%b busy=%b req=%b want 0 0 0", t, err, busy, sram_rd_req);
        end
      end
    end
  endtask

  task automatic test_start_while_busy();
    run_frame(4, 4, 24'($urandom), 1'b1, -1, 0, 1'b1, -1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (sram_rd_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        n_errors++;
        $display("FAIL no_extra_frame: req=%b busy=%b done=%b want 0 0 0", sram_rd_req, busy, done);
      end
    end
  endtask

  task automatic test_reset_midframe();
    run_frame(4, 4, 24'h000800, 1'b0, -1, 0, 1'b0, 2);
    run_frame(1, 1, 24'h000abc, 1'b0, -1, 0, 1'b0, -1);
  endtask

  task automatic test_addr_wrap();
    run_frame(4, 1, 24'hFFFFFE, 1'b0, -1, 0, 1'b0, -1);
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 6; f++)
      run_frame(int'($urandom_range(1, 5)), int'($urandom_range(1, 4)),
                24'($urandom), 1'b1, -1, 0, 1'b0, -1);
  endtask

  initial begin
    test_reset();
    test_basic_2x2();
    test_stall_3x1();
    test_zero_dim();
    test_start_while_busy();
    test_reset_midframe();
    test_addr_wrap();
    test_random_frames();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
